// File: rtl/inst_encoder_inject.sv
// inst_encoder_inject
// Encodes RISC-V style instruction requests into 32-bit words and buffers
// them in a small FIFO. Each entry is tagged with the PC and a sequence
// number at push time. Illegal requests are dropped and produce a
// one-cycle error pulse.
module inst_encoder_inject #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  // request side
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_fmt_i,
  input  logic [6:0]               req_opcode_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [6:0]               req_funct7_i,
  input  logic [4:0]               req_rd_i,
  input  logic [4:0]               req_rs1_i,
  input  logic [4:0]               req_rs2_i,
  input  logic [31:0]              req_imm_i,
  // control
  input  logic                     flush_i,
  input  logic                     load_pc_i,
  input  logic [31:0]              start_pc_i,
  // instruction side
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_pc_o,
  output logic [SEQ_W-1:0]         inst_seqNo_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  // FIFO storage
  logic [31:0]      r_mem_inst [DEPTH];
  logic [31:0]      r_mem_pc   [DEPTH];
  logic [SEQ_W-1:0] r_mem_seq  [DEPTH];

  // control state
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_pc;
  logic [SEQ_W-1:0] r_seq;
  logic             r_err;

  // combinational helpers
  logic [31:0]      w_enc;
  logic             w_illegal;
  logic             w_full;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [31:0]      w_pc_base;
  logic             w_unused_start_lsbs;

  // The low PC bits are forced to zero on load, so they are never read.
  assign w_unused_start_lsbs = ^start_pc_i[1:0];

  // Build the instruction word for the requested format and flag illegal requests.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned (which would infer a latch).
    w_enc     = '0;
    w_illegal = 1'b0;
    case (req_fmt_i)
      FMT_R:  w_enc = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      FMT_I:  w_enc = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      FMT_S:  w_enc = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                       req_imm_i[4:0], req_opcode_i};
      FMT_SB: w_enc = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                       req_imm_i[4:1], req_imm_i[11], req_opcode_i};
      FMT_U:  w_enc = {req_imm_i[31:12], req_rd_i, req_opcode_i};
      FMT_UJ: w_enc = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                       req_rd_i, req_opcode_i};
      default: w_enc = '0;
    endcase
    // Branch and jump offsets must be halfword aligned; formats 6/7 do not exist.
    if (req_fmt_i > FMT_UJ) begin
      w_illegal = 1'b1;
    end else if ((req_fmt_i == FMT_SB || req_fmt_i == FMT_UJ) && req_imm_i[0]) begin
      w_illegal = 1'b1;
    end
  end

  assign w_full      = (r_count == CW'(DEPTH));
  assign req_ready_o = !w_full;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_push      = w_accept && !w_illegal && !flush_i;
  assign w_pop       = inst_valid_o && inst_ready_i && !flush_i;
  // A rejected request freezes the PC, including any coincident load.
  assign w_load      = load_pc_i && !(w_accept && w_illegal);
  assign w_pc_base   = w_load ? {start_pc_i[31:2], 2'b00} : r_pc;

  // Pointer, occupancy, PC/seq counters and error pulse; reset beats flush beats everything else.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pc     <= '0;
      r_seq    <= '0;
      r_err    <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_pc     <= w_pc_base + 32'd4;
        r_seq    <= r_seq + SEQ_W'(1);
      end else if (w_load) begin
        r_pc     <= w_pc_base;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the encoded word and its tags into the slot at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy and pointers alone decide which entries are meaningful.
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= w_enc;
      r_mem_pc[r_wr_ptr]   <= w_pc_base;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_mem_inst[r_rd_ptr];
  assign inst_pc_o    = r_mem_pc[r_rd_ptr];
  assign inst_seqNo_o = r_mem_seq[r_rd_ptr];
  assign err_o        = r_err;
  assign count_o      = r_count;

endmodule

// File: tb/tb_inst_encoder_inject.sv
// Self-checking bench for inst_encoder_inject: a queue scoreboard predicts
// every popped instruction, and directed steps add literal checks for the
// known encodings, backpressure, rejection, flush and wrap cases.
module tb_inst_encoder_inject;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_fmt_i;
  logic [6:0]       req_opcode_i;
  logic [2:0]       req_funct3_i;
  logic [6:0]       req_funct7_i;
  logic [4:0]       req_rd_i;
  logic [4:0]       req_rs1_i;
  logic [4:0]       req_rs2_i;
  logic [31:0]      req_imm_i;
  logic             flush_i;
  logic             load_pc_i;
  logic [31:0]      start_pc_i;
  logic             inst_valid_o;
  logic             inst_ready_i;
  logic [31:0]      inst_o;
  logic [31:0]      inst_pc_o;
  logic [SEQ_W-1:0] inst_seqNo_o;
  logic             err_o;
  logic [CW-1:0]    count_o;

  inst_encoder_inject #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_fmt_i    (req_fmt_i),
    .req_opcode_i (req_opcode_i),
    .req_funct3_i (req_funct3_i),
    .req_funct7_i (req_funct7_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_imm_i    (req_imm_i),
    .flush_i      (flush_i),
    .load_pc_i    (load_pc_i),
    .start_pc_i   (start_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_seqNo_o (inst_seqNo_o),
    .err_o        (err_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [31:0]      m_pc  = '0;
  logic [SEQ_W-1:0] m_seq = '0;
  logic             m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Reference encoder, assembled bit by bit from the field layout.
  function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    w[6:0] = op;
    case (fmt)
      3'd0: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7; end
      3'd1: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0]; end
      3'd2: begin w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
                  w[31:25] = imm[11:5]; end
      3'd3: begin w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1;
                  w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12]; end
      3'd4: begin w[11:7] = rd; w[31:12] = imm[31:12]; end
      3'd5: begin w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
                  w[31] = imm[20]; end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(input logic [2:0] fmt, input logic [31:0] imm);
    if (fmt > 3'd5) return 1'b0;
    if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) return 1'b0;
    return 1'b1;
  endfunction

  // Compare status outputs, retire a popped entry, then predict this edge.
  task automatic sample();
    exp_t        e;
    logic [31:0] pc_base;
    bit          legal;
    check("count", 32'(count_o), 32'(sb.size()));
    check("inst_valid", 32'(inst_valid_o), 32'(sb.size() != 0));
    check("req_ready", 32'(req_ready_o), 32'(sb.size() < DEPTH));
    check("err", 32'(err_o), 32'(m_err));
    m_err = 1'b0;
    if (reset) begin
      sb.delete();
      m_pc  = '0;
      m_seq = '0;
      return;
    end
    if (flush_i) begin
      sb.delete();
      return;
    end
    if (inst_valid_o && inst_ready_i) begin
      if (sb.size() == 0) begin
        check("pop_without_expectation", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pop_inst", inst_o, e.inst);
        check("pop_pc", inst_pc_o, e.pc);
        check("pop_seq", 32'(inst_seqNo_o), 32'(e.seq));
      end
    end
    legal   = ref_legal(req_fmt_i, req_imm_i);
    pc_base = (load_pc_i && !(req_valid_i && req_ready_o && !legal))
              ? {start_pc_i[31:2], 2'b00} : m_pc;
    if (req_valid_i && req_ready_o) begin
      if (legal) begin
        e.inst = ref_encode(req_fmt_i, req_opcode_i, req_funct3_i, req_funct7_i,
                            req_rd_i, req_rs1_i, req_rs2_i, req_imm_i);
        e.pc   = pc_base;
        e.seq  = m_seq;
        sb.push_back(e);
        m_pc  = pc_base + 32'd4;
        m_seq = m_seq + 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_pc = pc_base;
    end
  endtask

  task automatic finish_cycle();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    load_pc_i   = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    req_valid_i  = 1'b1;
    req_fmt_i    = fmt;
    req_opcode_i = op;
    req_funct3_i = f3;
    req_funct7_i = f7;
    req_rd_i     = rd;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_imm_i    = imm;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    int budget;
    idle();
    inst_ready_i = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      cycle();
      budget++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [6:0]  r_op;

    reset        = 1'b1;
    inst_ready_i = 1'b1;
    start_pc_i   = '0;
    idle();
    set_req(3'd0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    req_valid_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state is checked by the first sample while reset is still high.
    cycle();
    reset = 1'b0;

    // I-type push, visible the following cycle with PC 0 and seq 0.
    set_req(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle();
    idle();
    @(negedge clk);
    check("itype_inst", inst_o, 32'h00500093);
    check("itype_pc", inst_pc_o, 32'h0);
    check("itype_seq", 32'(inst_seqNo_o), 32'h0);
    finish_cycle();

    // SB-type push with a negative offset.
    set_req(3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    cycle();
    idle();
    @(negedge clk);
    check("sbtype_inst", inst_o, 32'hFE208CE3);
    check("sbtype_pc", inst_pc_o, 32'h4);
    finish_cycle();

    // Reset with entries buffered discards them.
    inst_ready_i = 1'b0;
    set_req(3'd4, 7'h37, 3'd0, 7'h0, 5'd3, 5'd0, 5'd0, 32'hABCD_E000);
    cycle();
    cycle();
    do_reset();
    cycle();

    // Backpressure: five back-to-back pushes, fifth held until space frees.
    inst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(3'd1, 7'h13, 3'd0, 7'h0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
      cycle();
    end
    @(negedge clk);
    check("full_ready", 32'(req_ready_o), 32'd0);
    check("full_count", 32'(count_o), 32'd4);
    check("full_head_pc", inst_pc_o, 32'h0);
    inst_ready_i = 1'b1;
    finish_cycle();
    drain();

    // Rejections: misaligned UJ and format 7 pulse err and leave state alone.
    do_reset();
    set_req(3'd5, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd3);
    cycle();
    set_req(3'd7, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd4);
    @(negedge clk);
    check("rej1_err", 32'(err_o), 32'd1);
    finish_cycle();
    idle();
    @(negedge clk);
    check("rej2_err", 32'(err_o), 32'd1);
    check("rej_count", 32'(count_o), 32'd0);
    finish_cycle();
    set_req(3'd5, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'h0000_0804);
    cycle();
    idle();
    @(negedge clk);
    check("after_rej_seq", 32'(inst_seqNo_o), 32'd0);
    check("after_rej_err", 32'(err_o), 32'd0);
    finish_cycle();

    // Flush with a same-cycle push; counters survive the flush.
    do_reset();
    inst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd2, 7'h23, 3'd2, 7'h0, 5'd0, 5'(i), 5'(i + 4), 32'(i * 8));
      cycle();
    end
    flush_i = 1'b1;
    set_req(3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'h0);
    cycle();
    idle();
    @(negedge clk);
    check("flush_count", 32'(count_o), 32'd0);
    finish_cycle();
    inst_ready_i = 1'b1;
    set_req(3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'h0);
    cycle();
    idle();
    @(negedge clk);
    check("postflush_pc", inst_pc_o, 32'd12);
    check("postflush_seq", 32'(inst_seqNo_o), 32'd3);
    finish_cycle();

    // Wrap: 300 push/pop pairs across all formats, PC loaded on the first.
    do_reset();
    inst_ready_i = 1'b1;
    start_pc_i   = 32'h8000_0002;
    for (int i = 0; i < 300; i++) begin
      r_imm = $urandom;
      r_imm[0] = 1'b0;
      r_rd  = 5'($urandom);
      r_rs1 = 5'($urandom);
      r_rs2 = 5'($urandom);
      r_f3  = 3'($urandom);
      r_f7  = 7'($urandom);
      r_op  = 7'($urandom);
      set_req(3'(i % 6), r_op, r_f3, r_f7, r_rd, r_rs1, r_rs2, r_imm);
      load_pc_i = (i == 0);
      @(negedge clk);
      if (i == 1)   check("wrap_first_pc", inst_pc_o, 32'h8000_0000);
      if (i == 256) check("wrap_seq_255", 32'(inst_seqNo_o), 32'd255);
      if (i == 257) check("wrap_seq_0", 32'(inst_seqNo_o), 32'd0);
      finish_cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
